// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - RV32M multi-cycle multiply/divide sequencer with shift-add and restoring-divide datapath
module muldiv_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        Funct3,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Result
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    state_t state, state_next;

    logic [2:0]          f3;
    logic                sign;
    logic [CW-1:0]       cnt;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   opb;

    logic              accept, a_signed, b_signed, a_neg, b_neg, sign_in;
    logic              div_zero, div_ovf;
    logic [DATA_W-1:0] a_mag, b_mag, special_res;

    assign accept   = (state == IDLE) && start && !flush;
    assign a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    assign b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    assign a_neg    = a_signed && SrcA[DATA_W-1];
    assign b_neg    = b_signed && SrcB[DATA_W-1];
    assign a_mag    = a_neg ? -SrcA : SrcA;
    assign b_mag    = b_neg ? -SrcB : SrcB;
    // Remainder takes the dividend's sign; everything else the product of signs.
    assign sign_in  = (Funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = Funct3[2] && (SrcB == '0);
    assign div_ovf  = Funct3[2] && !Funct3[0] && (SrcA == {1'b1, {(DATA_W-1){1'b0}}}) && (SrcB == '1);
    assign special_res = div_zero ? (Funct3[1] ? SrcA : '1)
                                  : (Funct3[1] ? '0 : {1'b1, {(DATA_W-1){1'b0}}});

    assign stall = accept || busy;

    // prod holds {acc, multiplier} while multiplying and {rem, quot} while dividing.
    logic [DATA_W:0]     mul_sum, rem_sh;
    logic [DATA_W-1:0]   rem_sub;
    logic                rem_ge;
    logic [2*DATA_W-1:0] mul_next, div_next;

    assign mul_sum  = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, opb} : '0);
    assign mul_next = {mul_sum, prod[DATA_W-1:1]};
    assign rem_sh   = {prod[2*DATA_W-1:DATA_W], prod[DATA_W-1]};
    assign rem_ge   = rem_sh >= {1'b0, opb};
    assign rem_sub  = rem_sh[DATA_W-1:0] - opb;
    assign div_next = rem_ge ? {rem_sub, prod[DATA_W-2:0], 1'b1}
                             : {rem_sh[DATA_W-1:0], prod[DATA_W-2:0], 1'b0};

    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   q_fix, r_fix, fix_res;

    assign prod_fix = sign ? -prod : prod;
    assign q_fix    = sign ? -prod[DATA_W-1:0] : prod[DATA_W-1:0];
    assign r_fix    = sign ? -prod[2*DATA_W-1:DATA_W] : prod[2*DATA_W-1:DATA_W];

    always_comb begin
        fix_res = '0;
        case (f3)
            3'b000:                 fix_res = prod_fix[DATA_W-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*DATA_W-1:DATA_W];
            3'b100, 3'b101:         fix_res = q_fix;
            default:                fix_res = r_fix;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!Funct3[2])               state_next = MUL;
                    else if (div_zero || div_ovf) state_next = DONE;
                    else                          state_next = DIV;
                end
            end
            MUL, DIV: begin
                if (flush)                  state_next = IDLE;
                else if (cnt == LAST_STEP)  state_next = FIX;
            end
            FIX:     state_next = flush ? IDLE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            Result <= '0;
            cnt    <= '0;
            f3     <= '0;
            sign   <= 1'b0;
            prod   <= '0;
            opb    <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == MUL) || (state_next == DIV) || (state_next == FIX);
            done  <= (state_next == DONE);
            if (accept) begin
                f3   <= Funct3;
                sign <= sign_in;
                cnt  <= '0;
                prod <= {{DATA_W{1'b0}}, (Funct3[2] ? a_mag : b_mag)};
                opb  <= Funct3[2] ? b_mag : a_mag;
            end else if (state == MUL) begin
                prod <= mul_next;
                cnt  <= cnt + 1'b1;
            end else if (state == DIV) begin
                prod <= div_next;
                cnt  <= cnt + 1'b1;
            end
            if (state == IDLE && state_next == DONE)
                Result <= special_res;
            else if (state == FIX && state_next == DONE)
                Result <= fix_res;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;
    logic        stall, busy, done;
    logic [31:0] Result;

    int n_pass = 0;
    int n_total = 0;

    muldiv_sequencer #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .Result(Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int  k;
        logic stall_ok;
        @(negedge clk);
        Funct3 = f3; SrcA = a; SrcB = b; start = 1'b1;
        #1 check({tag, "_stall_accept"}, 32'(stall), 32'd1);
        stall_ok = 1'b1;
        k = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done) begin
                k = i;
                break;
            end
            if (!stall) stall_ok = 1'b0;
        end
        check({tag, "_latency"}, 32'(k), 32'(lat));
        check({tag, "_stall_held"}, 32'(stall_ok), 32'd1);
        check({tag, "_result"}, Result, exp);
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        #1;
        check({tag, "_no_reaccept"}, 32'(busy), 32'd0);
        check({tag, "_result_hold"}, Result, exp);
    endtask

    initial begin
        logic no_done;
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        Funct3 = '0; SrcA = '0; SrcB = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_result", Result, 32'd0);
        reset = 1'b0;

        run_op("mul_7x6",      3'b000, 32'd7,        32'd6,        32'd42,        34);
        run_op("mul_m1xm1",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  34);
        run_op("mulh",         3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,  34);
        run_op("mulhsu",       3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,  34);
        run_op("mulhu",        3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  34);
        run_op("divu_by0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF,  1);
        run_op("rem_by0",      3'b110, 32'd5,        32'd0,        32'd5,         1);
        run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1);
        run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000,  1);
        run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  34);
        run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  34);
        run_op("div_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,  34);
        run_op("rem_7_m2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,         34);
        run_op("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,        34);
        run_op("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,         34);

        // Flush ten cycles into a multiply: no done, Result keeps 2.
        @(negedge clk);
        Funct3 = 3'b000; SrcA = 32'd7; SrcB = 32'd6; start = 1'b1;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_result", Result, 32'd2);
        no_done = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy) no_done = 1'b0;
        end
        check("flush_quiet", 32'(no_done), 32'd1);
        run_op("divu_9_3",     3'b101, 32'd9,        32'd3,        32'd3,         34);

        // Reset five cycles into a divide.
        @(negedge clk);
        Funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", Result, 32'd0);
        reset = 1'b0;
        run_op("divu_after_rst", 3'b101, 32'd100,    32'd7,        32'd14,        34);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
